// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and constants for the hazard scoreboard.
package hazard_scoreboard_pkg;

  // Next-PC selector driven by decode.
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_e;

  // A producer blocks a consumer while its counter is above the consumer's threshold.
  // ID-resolved consumers (branch, JR) need data one stage earlier than EX consumers.
  localparam int TH_ID = 1;
  localparam int TH_EX = 2;

  // Initial counts written for a destination at issue.
  localparam int LOAD_CNT_BASE = 2;
  localparam int ALU_CNT       = 1;

  // Count loaded for a load destination given the extra memory latency.
  function automatic int load_cnt(input int load_lat);
    return load_lat + LOAD_CNT_BASE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating down-counter with load, hold and synchronous reset.
module sb_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_hold,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Reset clears, load overrides, hold freezes, otherwise count down to zero.
  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: each instance resets synchronously; a stale count after rst would invent hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit: drives PC / IF/ID enables and pipeline flushes.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32,
  parameter int CNT_W    = 8,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              id_is_muldiv,
  input  logic              id_reads_hilo,
  input  logic [1:0]        npc_ctrl,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(load_cnt(LOAD_LAT));
  localparam logic [CNT_W-1:0] ALU_VAL  = CNT_W'(ALU_CNT);
  localparam logic [CNT_W-1:0] MD_VAL   = CNT_W'(MD_LAT);

  npc_e              w_npc;
  logic [CNT_W-1:0]  w_th;
  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [CNT_W-1:0]  w_md_cnt;
  logic [CNT_W-1:0]  w_wr_val;
  logic              w_src_rs, w_src_rt;
  logic              w_rs_pend, w_rt_pend, w_md_pend;
  logic              w_data_stall, w_issue, w_redirect;
  logic [PERF_W-1:0] r_stall_cycles;

  assign w_npc      = npc_e'(npc_ctrl);
  assign w_th       = ((w_npc == NPC_BR) || (w_npc == NPC_JR)) ? CNT_W'(TH_ID) : CNT_W'(TH_EX);
  assign w_src_rs   = id_valid && id_uses_rs && (id_rs != '0);
  assign w_src_rt   = id_valid && id_uses_rt && (id_rt != '0);
  assign w_rs_pend  = w_src_rs && (w_cnt[id_rs] > w_th);
  assign w_rt_pend  = w_src_rt && (w_cnt[id_rt] > w_th);
  assign w_md_pend  = id_valid && (id_reads_hilo || id_is_muldiv) && (w_md_cnt != '0);
  assign w_data_stall = w_rs_pend || w_rt_pend || w_md_pend;
  assign w_issue    = id_valid && !w_data_stall && !mem_busy;
  assign w_redirect = ((w_npc == NPC_BR) && branch_taken) || npc_ctrl[1];
  assign w_wr_val   = id_is_load ? LOAD_VAL : ALU_VAL;

  // One counter per GPR; r0 is never loaded so it never reads as pending.
  for (genvar g = 0; g < NREG; g++) begin : g_sb
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_issue && id_wr_en && (id_dst != '0) && (id_dst == REG_AW'(g))),
      .i_load_val (w_wr_val),
      .i_hold     (mem_busy),
      .o_cnt      (w_cnt[g])
    );
  end

  // MULT/DIV busy tracker runs independently of the memory freeze.
  sb_counter #(.CNT_W(CNT_W)) u_md_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_issue && id_is_muldiv),
    .i_load_val (MD_VAL),
    .i_hold     (1'b0),
    .o_cnt      (w_md_cnt)
  );

  // Count cycles lost to data hazards; memory freezes are not attributed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_data_stall && !mem_busy) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

  // Prioritised enable/flush decode: reset, memory freeze, data stall, redirect, run.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_we = 1'b1;
    end else if (mem_busy) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (w_data_stall) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (w_redirect) begin
      if_id_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed table, multi-cycle sequences and random stimulus vs a timestamp model.
module tb_hazard_scoreboard;

  localparam int MDL = 4;
  localparam logic [3:0] E_RUN = 4'b1100;
  localparam logic [3:0] E_STL = 4'b0001;
  localparam logic [3:0] E_RED = 4'b1110;
  localparam logic [3:0] E_FRZ = 4'b0000;

  typedef struct packed {
    logic        rst, valid;
    logic [4:0]  rs, rt;
    logic        uses_rs, uses_rt, wr_en;
    logic [4:0]  dst;
    logic        is_load, is_muldiv, reads_hilo;
    logic [1:0]  npc;
    logic        taken, busy;
    logic [3:0]  exp;
    logic        chk_sc;
    logic [31:0] sc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_uses_rs, id_uses_rt, id_wr_en;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_is_load, id_is_muldiv, id_reads_hilo, branch_taken, mem_busy;
  logic [1:0] npc_ctrl;

  logic        pc_we1, if_id_we1, if_id_flush1, id_ex_flush1;
  logic        pc_we3, if_id_we3, if_id_flush3, id_ex_flush3;
  logic [31:0] sc1, sc3;
  logic [3:0]  ctl1, ctl3, s3_ctl;
  assign ctl1 = {pc_we1, if_id_we1, if_id_flush1, id_ex_flush1};
  assign ctl3 = {pc_we3, if_id_we3, if_id_flush3, id_ex_flush3};

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(MDL), .CNT_W(8), .PERF_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .npc_ctrl(npc_ctrl), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we1), .if_id_we(if_id_we1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
    .stall_cycles(sc1));

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(MDL), .CNT_W(8), .PERF_W(32)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .npc_ctrl(npc_ctrl), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we3), .if_id_we(if_id_we3), .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3),
    .stall_cycles(sc3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: each register holds the pipeline time at which it stops being
  // pending; pipeline time only advances when memory is not busy. MULT/DIV uses wall time.
  longint      ready [2][32];
  longint      md_ready [2];
  longint      ptime = 0;
  longint      rtime = 0;
  logic [31:0] msc [2];
  int          lat [2] = '{1, 3};

  function automatic logic m_stall(input int k);
    longint th;
    logic   s;
    th = ((npc_ctrl == 2'b01) || (npc_ctrl == 2'b11)) ? 1 : 2;
    s  = 1'b0;
    if (id_valid && id_uses_rs && (id_rs != 0) && (ready[k][id_rs] - ptime > th)) s = 1'b1;
    if (id_valid && id_uses_rt && (id_rt != 0) && (ready[k][id_rt] - ptime > th)) s = 1'b1;
    if (id_valid && (id_reads_hilo || id_is_muldiv) && (md_ready[k] > rtime)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [3:0] m_out(input int k);
    if (rst) return E_RUN;
    if (mem_busy) return E_FRZ;
    if (m_stall(k)) return E_STL;
    if (((npc_ctrl == 2'b01) && branch_taken) || npc_ctrl[1]) return E_RED;
    return E_RUN;
  endfunction

  task automatic m_advance();
    logic st;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
        md_ready[k] = 0;
        msc[k] = 32'd0;
      end else begin
        st = m_stall(k);
        if (!mem_busy && st) msc[k] = msc[k] + 32'd1;
        if (id_valid && !st && !mem_busy) begin
          if (id_wr_en && (id_dst != 0))
            ready[k][id_dst] = ptime + 1 + (id_is_load ? lat[k] + 2 : 1);
          if (id_is_muldiv) md_ready[k] = rtime + 1 + MDL;
        end
      end
    end
    if (!mem_busy) ptime++;
    rtime++;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt; id_wr_en = v.wr_en; id_dst = v.dst;
    id_is_load = v.is_load; id_is_muldiv = v.is_muldiv; id_reads_hilo = v.reads_hilo;
    npc_ctrl = v.npc; branch_taken = v.taken; mem_busy = v.busy;
  endtask

  // One clock: drive, compare mid-cycle, advance the model, cross the edge.
  task automatic run_vec(input vec_t v, input bit tbl, input string tag);
    apply(v);
    #2;
    check($sformatf("%s ctl lat1", tag), 64'(ctl1), 64'(m_out(0)));
    check($sformatf("%s ctl lat3", tag), 64'(ctl3), 64'(m_out(1)));
    if (!rst) begin
      check($sformatf("%s stalls lat1", tag), 64'(sc1), 64'(msc[0]));
      check($sformatf("%s stalls lat3", tag), 64'(sc3), 64'(msc[1]));
    end
    if (tbl) begin
      check($sformatf("%s ctl table", tag), 64'(ctl1), 64'(v.exp));
      if (v.chk_sc) check($sformatf("%s stalls table", tag), 64'(sc1), 64'(v.sc));
    end
    s3_ctl = ctl3;
    m_advance();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t nop();
    vec_t v = '0;
    return v;
  endfunction
  function automatic vec_t ld(input logic [4:0] d);
    vec_t v = '0;
    v.valid = 1; v.wr_en = 1; v.dst = d; v.is_load = 1;
    return v;
  endfunction
  function automatic vec_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    vec_t v = '0;
    v.valid = 1; v.wr_en = 1; v.dst = d; v.rs = a; v.rt = b; v.uses_rs = 1; v.uses_rt = 1;
    return v;
  endfunction
  function automatic vec_t br(input logic [4:0] a, input logic [4:0] b, input logic t);
    vec_t v = '0;
    v.valid = 1; v.rs = a; v.rt = b; v.uses_rs = 1; v.uses_rt = 1; v.npc = 2'b01; v.taken = t;
    return v;
  endfunction
  function automatic vec_t jr(input logic [4:0] a);
    vec_t v = '0;
    v.valid = 1; v.rs = a; v.uses_rs = 1; v.npc = 2'b11;
    return v;
  endfunction
  function automatic vec_t jal();
    vec_t v = '0;
    v.valid = 1; v.wr_en = 1; v.dst = 5'd31; v.npc = 2'b10;
    return v;
  endfunction
  function automatic vec_t mult();
    vec_t v = '0;
    v.valid = 1; v.is_muldiv = 1;
    return v;
  endfunction
  function automatic vec_t mfhi(input logic [4:0] d);
    vec_t v = '0;
    v.valid = 1; v.reads_hilo = 1; v.wr_en = 1; v.dst = d;
    return v;
  endfunction

  vec_t tbl [$];

  task automatic put(input vec_t v, input logic [3:0] e, input logic busy = 1'b0,
                     input logic r = 1'b0, input logic chk = 1'b0, input logic [31:0] sc = 32'd0);
    v.exp = e; v.busy = busy; v.rst = r; v.chk_sc = chk; v.sc = sc;
    tbl.push_back(v);
  endtask

  initial begin
    int   stalls;
    vec_t v;
    msc[0] = 32'd0;
    msc[1] = 32'd0;

    // Reset, then idle.
    put(nop(), E_RUN, 0, 1);
    put(nop(), E_RUN, 0, 1);
    put(nop(), E_RUN, 0, 0, 1, 0);
    // Load r5 -> dependent ALU: one stall.
    put(ld(5), E_RUN);
    put(alu(6, 5, 1), E_STL);
    put(alu(6, 5, 1), E_RUN, 0, 0, 1, 1);
    // Load r5 -> dependent taken branch: two stalls then redirect.
    put(ld(5), E_RUN);
    put(br(5, 0, 1), E_STL);
    put(br(5, 0, 1), E_STL);
    put(br(5, 0, 1), E_RED, 0, 0, 1, 3);
    put(nop(), E_RUN);
    // ALU r7 -> JR r7 forwards; r0 is never pending; JAL then JR r31.
    put(alu(7, 1, 2), E_RUN);
    put(jr(7), E_RED, 0, 0, 1, 3);
    put(ld(0), E_RUN);
    put(alu(8, 0, 0), E_RUN, 0, 0, 1, 3);
    put(jal(), E_RED);
    put(jr(31), E_RED);
    // MULT -> MFHI: blocked while the MD counter is nonzero.
    put(mult(), E_RUN);
    for (int i = 0; i < MDL; i++) put(mfhi(9), E_STL);
    put(mfhi(9), E_RUN, 0, 0, 1, 7);
    // Same with a two-cycle memory freeze in the middle; MD counter keeps running.
    put(mult(), E_RUN);
    put(mfhi(9), E_STL);
    put(mfhi(9), E_FRZ, 1);
    put(mfhi(9), E_FRZ, 1);
    put(mfhi(9), E_STL);
    put(mfhi(9), E_RUN, 0, 0, 1, 9);
    // Load r5 then dependent ALU under a 3-cycle freeze: counters hold.
    put(ld(5), E_RUN);
    put(alu(6, 5, 0), E_FRZ, 1, 0, 1, 9);
    put(alu(6, 5, 0), E_FRZ, 1);
    put(alu(6, 5, 0), E_FRZ, 1, 0, 1, 9);
    put(alu(6, 5, 0), E_STL, 0, 0, 1, 9);
    put(alu(6, 5, 0), E_RUN, 0, 0, 1, 10);
    // Reset during a pending load stall clears everything.
    put(ld(5), E_RUN);
    put(alu(6, 5, 0), E_RUN, 0, 1);
    put(alu(6, 5, 0), E_RUN, 0, 0, 1, 0);
    put(br(5, 0, 1), E_RED);
    // Reset during a MULT/DIV stall clears the MD counter.
    put(mult(), E_RUN);
    put(mfhi(9), E_STL);
    put(mfhi(9), E_RUN, 0, 1);
    put(mfhi(9), E_RUN, 0, 0, 1, 0);

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // LOAD_LAT=3 instance: load -> taken branch needs four stalls, then redirects.
    for (int i = 0; i < 8; i++) run_vec(nop(), 1'b0, "drain");
    run_vec(ld(5), 1'b0, "lat3 load");
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      run_vec(br(5, 0, 1), 1'b0, "lat3 br");
      if (s3_ctl != E_STL) break;
      stalls++;
    end
    check("lat3 stall count", 64'(stalls), 64'd4);
    check("lat3 release redirect", 64'(s3_ctl), 64'(E_RED));

    // Random traffic on a small register window for dense hazards.
    for (int n = 0; n < 3000; n++) begin
      v = '0;
      v.rst        = ($urandom_range(0, 99) == 0);
      v.valid      = ($urandom_range(0, 3) != 0);
      v.rs         = 5'($urandom_range(0, 7));
      v.rt         = 5'($urandom_range(0, 7));
      v.dst        = 5'($urandom_range(0, 7));
      v.uses_rs    = 1'($urandom_range(0, 1));
      v.uses_rt    = 1'($urandom_range(0, 1));
      v.wr_en      = 1'($urandom_range(0, 1));
      v.is_load    = ($urandom_range(0, 2) == 0);
      v.is_muldiv  = ($urandom_range(0, 15) == 0);
      v.reads_hilo = ($urandom_range(0, 7) == 0);
      v.npc        = 2'($urandom_range(0, 3));
      v.taken      = 1'($urandom_range(0, 1));
      v.busy       = ($urandom_range(0, 5) == 0);
      run_vec(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
